bus_demux_1to8: RTL and testbench
=================================

Name: bus_demux_1to8

Overview:
- Registered 1-to-8 demultiplexer for the unidirectional bus return path. It is the inverse of the 8-to-1 select mux used on the request path.
- Accepts one beat per cycle from a single upstream stream. It routes the beat by a 3-bit select to one of eight downstream channels, each backed by a one-entry holding register.
- A valid/ready handshake on every side lets a stalled requester back-pressure the shared stream without corrupting the other channels.

Parameters:
- BITWIDTH, 8, data width of each beat and of each output channel.
- CNTWIDTH, 16, width of the accepted-beat counter.

Ports:
- Clk  input  1  single clock; all state updates on the rising edge.
- Rst_n  input  1  asynchronous, active-low reset.
- Flush  input  1  synchronous clear of all holding registers.
- DataIn  input  BITWIDTH  upstream beat.
- Sel  input  3  destination channel: 0 selects channel 1, 7 selects channel 8.
- InValid  input  1  upstream beat present.
- InReady  output  1  demux can accept the beat this cycle.
- DataOutFlat  output  BITWIDTH*8  channel data. Channel 1 occupies [BITWIDTH*8-1:BITWIDTH*7], down to channel 8 at [BITWIDTH-1:0].
- OutValid  output  8  per-channel valid; bit 7 = channel 1, bit 0 = channel 8.
- OutReady  input  8  per-channel consumer ready, same bit order as OutValid.
- AcceptCount  output  CNTWIDTH  total beats accepted since reset or Flush.

Behaviour:
- Reset (Rst_n low, asynchronous): all eight holding registers = 0; OutValid = 8'h00; AcceptCount = 0. InReady is combinational and therefore reads 1 during reset release.
- Slot index: k = 7 - Sel, so channel 1 maps to OutValid[7], matching the flattened data order.
- InReady = ~OutValid[k] | OutReady[k].
  - Depends only on the selected slot; other slots never block.
  - Combinational from Sel, OutValid and OutReady. It must not depend on InValid.
- Accept condition: InValid & InReady & ~Flush.
  - On accept, slot k loads DataIn and OutValid[k] = 1 at the next edge.
  - Latency from accept to OutValid is 1 cycle.
- Drain: a slot with OutValid[j] & OutReady[j] clears OutValid[j] at the next edge, unless it is reloaded in the same cycle.
- Simultaneous drain and load on the same slot: the slot loads the new beat and OutValid stays 1. This gives full throughput of one beat per cycle per channel.
- Non-selected slots hold data and valid until drained. DataOutFlat slices are stable while the corresponding OutValid = 1 and OutReady = 0.
- Flush:
  - At the next edge, all OutValid = 0 and AcceptCount = 0.
  - Data registers may retain stale values.
  - A beat presented in the same cycle is not accepted and is not counted.
  - Flush has priority over accept and drain.
- AcceptCount increments by 1 per accept and wraps modulo 2^CNTWIDTH without saturation.
- Holding registers need no reset value beyond the valid bits. They are reset to 0 for deterministic simulation.
- Reset mid-transfer: every pending beat is discarded and no stale OutValid survives reset.
- Sel is decoded only when InValid = 1. Upstream must hold DataIn and Sel stable while InValid = 1 and InReady = 0.

Decomposition:
- A shared package holds:
  - NUM_CH = 8
  - SEL_WIDTH = 3
  - the slot-index function (7 - Sel)
  - the slice-offset function (k*BITWIDTH)
- One natural sub-module: demux_slot.
  - One-entry register with load/drain/flush inputs and data/valid outputs.
  - Instantiated eight times in a generate loop.
- Top level holds:
  - the Sel decode to a one-hot load vector
  - the InReady mux
  - the counter

Test Plan:
1. Reset, then InValid=1, Sel=0, DataIn=8'hA5, OutReady=8'hFF -> next cycle OutValid=8'h80 and DataOutFlat[63:56]=8'hA5; the cycle after, OutValid=8'h00; AcceptCount=1.
2. Back-pressure: OutReady[0]=0, send Sel=7 DataIn=8'h11 then Sel=7 DataIn=8'h22 -> first accepted; InReady=0 for the second, which is held until OutReady[0]=1. Channel 8 then shows 8'h11 followed by 8'h22; AcceptCount=2.
3. Isolation: channel 8 stalled with a pending beat; stream Sel=0..6 with DataIn=8'h30+Sel -> all seven accepted back-to-back with InReady=1; each slice holds its own value; channel 8 data unchanged.
4. Same-cycle drain and load: slot for Sel=3 full with 8'h44, OutReady=8'hFF, send Sel=3 DataIn=8'h55 -> InReady=1; next cycle OutValid[4]=1 with data 8'h55 and no bubble.
5. Flush with channels 1, 4 and 8 valid and InValid=1 -> next cycle OutValid=8'h00, AcceptCount=0, and the incoming beat is dropped.
6. Counter wrap with CNTWIDTH=4: 17 accepts -> AcceptCount=1. Asserting Rst_n low mid-stream -> OutValid=0 and AcceptCount=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/bus_demux_1to8_pkg.sv
// Shared constants and index helpers for the 1-to-8 return-path demux.
package bus_demux_1to8_pkg;

  localparam int NUM_CH    = 8;
  localparam int SEL_WIDTH = 3;

  // Channel 1 (Sel=0) lives in the top slot so valid bits and data slices line up.
  function automatic logic [SEL_WIDTH-1:0] slot_idx(input logic [SEL_WIDTH-1:0] sel);
    return SEL_WIDTH'(NUM_CH - 1) - sel;
  endfunction

  // Bit offset of slot k inside the flattened data bus.
  function automatic int slice_off(input int k, input int bw);
    return k * bw;
  endfunction

endpackage

// File: rtl/bus_demux_1to8_slot.sv
// One-entry holding register for a single downstream channel.
module demux_slot #(
  parameter int BITWIDTH = 8
) (
  input  logic                Clk,
  input  logic                Rst_n,
  input  logic                flush,
  input  logic                load,
  input  logic                ready,
  input  logic [BITWIDTH-1:0] din,
  output logic [BITWIDTH-1:0] dout,
  output logic                valid
);

  // Flush beats load beats drain; a load during drain keeps the slot full.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      dout  <= '0;
      valid <= 1'b0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      dout  <= din;
      valid <= 1'b1;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/bus_demux_1to8.sv
// Registered 1-to-8 demux: routes one upstream beat per cycle to a channel slot.
module bus_demux_1to8
  import bus_demux_1to8_pkg::*;
#(
  parameter int BITWIDTH = 8,
  parameter int CNTWIDTH = 16
) (
  input  logic                       Clk,
  input  logic                       Rst_n,
  input  logic                       Flush,
  input  logic [BITWIDTH-1:0]        DataIn,
  input  logic [SEL_WIDTH-1:0]       Sel,
  input  logic                       InValid,
  output logic                       InReady,
  output logic [BITWIDTH*NUM_CH-1:0] DataOutFlat,
  output logic [NUM_CH-1:0]          OutValid,
  input  logic [NUM_CH-1:0]          OutReady,
  output logic [CNTWIDTH-1:0]        AcceptCount
);

  logic [SEL_WIDTH-1:0] k;
  logic                 accept;
  logic [NUM_CH-1:0]    load;

  assign k = slot_idx(Sel);

  // Only the addressed slot can stall the stream; InValid is deliberately not used.
  assign InReady = ~OutValid[k] | OutReady[k];
  assign accept  = InValid & InReady & ~Flush;

  // One-hot load strobe for the addressed slot.
  always_comb begin
    load = '0;
    if (accept) load[k] = 1'b1;
  end

  // Accepted-beat counter, wraps freely, cleared by Flush.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n)      AcceptCount <= '0;
    else if (Flush)  AcceptCount <= '0;
    else if (accept) AcceptCount <= AcceptCount + CNTWIDTH'(1);
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_slot
    localparam int OFF = slice_off(g, BITWIDTH);
    demux_slot #(.BITWIDTH(BITWIDTH)) u_slot (
      .Clk   (Clk),
      .Rst_n (Rst_n),
      .flush (Flush),
      .load  (load[g]),
      .ready (OutReady[g]),
      .din   (DataIn),
      .dout  (DataOutFlat[OFF +: BITWIDTH]),
      .valid (OutValid[g])
    );
  end

endmodule

// File: tb/tb_bus_demux_1to8.sv
// Self-checking bench for bus_demux_1to8: directed table, corner sequences, random vs model.
module tb_bus_demux_1to8;

  localparam int BW = 8;
  localparam int CW = 4;

  logic          Clk = 1'b0;
  logic          Rst_n = 1'b0;
  logic          Flush = 1'b0;
  logic [BW-1:0] DataIn = '0;
  logic [2:0]    Sel = '0;
  logic          InValid = 1'b0;
  logic          InReady;
  logic [BW*8-1:0] DataOutFlat;
  logic [7:0]    OutValid;
  logic [7:0]    OutReady = '0;
  logic [CW-1:0] AcceptCount;

  bus_demux_1to8 #(.BITWIDTH(BW), .CNTWIDTH(CW)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Flush(Flush), .DataIn(DataIn), .Sel(Sel),
    .InValid(InValid), .InReady(InReady), .DataOutFlat(DataOutFlat),
    .OutValid(OutValid), .OutReady(OutReady), .AcceptCount(AcceptCount)
  );

  always #5 Clk = ~Clk;

  int errors = 0;
  int checks = 0;

  // Reference model indexed by channel number minus one (channel 1 = index 0).
  logic [7:0] m_data [8];
  bit         m_vld  [8];
  int         m_cnt;

  typedef struct {
    bit fl; bit iv; logic [2:0] sel; logic [7:0] din; logic [7:0] ordy;
    bit exp_rdy; logic [7:0] exp_vld; int exp_cnt;
    bit chk; logic [2:0] chk_sel; logic [7:0] chk_data;
  } vec_t;

  function automatic vec_t mk(bit fl, bit iv, logic [2:0] sel, logic [7:0] din, logic [7:0] ordy,
                              bit er, logic [7:0] ev, int ec, bit c, logic [2:0] cs, logic [7:0] cd);
    vec_t v;
    v.fl = fl; v.iv = iv; v.sel = sel; v.din = din; v.ordy = ordy;
    v.exp_rdy = er; v.exp_vld = ev; v.exp_cnt = ec;
    v.chk = c; v.chk_sel = cs; v.chk_data = cd;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit model_ready(logic [2:0] sel, logic [7:0] ordy);
    int ch = int'(sel);
    return !m_vld[ch] || ordy[7 - ch];
  endfunction

  function automatic logic [7:0] model_vld();
    logic [7:0] r = '0;
    for (int c = 0; c < 8; c++) r[7 - c] = m_vld[c];
    return r;
  endfunction

  task automatic model_clear();
    for (int c = 0; c < 8; c++) begin m_data[c] = '0; m_vld[c] = 0; end
    m_cnt = 0;
  endtask

  // Compare valid bits, counter and the data of every channel the model considers full.
  task automatic check_model(input string tag);
    logic [63:0] mask = '0;
    logic [63:0] expd = '0;
    for (int c = 0; c < 8; c++) if (m_vld[c]) begin
      mask[(7 - c) * 8 +: 8] = 8'hFF;
      expd[(7 - c) * 8 +: 8] = m_data[c];
    end
    check({tag, "_valid"}, 64'(OutValid), 64'(model_vld()));
    check({tag, "_count"}, 64'(AcceptCount), 64'(m_cnt));
    check({tag, "_data"}, DataOutFlat & mask, expd);
  endtask

  // Apply one cycle of inputs (called just after a rising edge), advance model, compare.
  task automatic step(input bit fl, input bit iv, input logic [2:0] sel, input logic [7:0] din,
                      input logic [7:0] ordy, input string tag);
    bit acc;
    Flush = fl; InValid = iv; Sel = sel; DataIn = din; OutReady = ordy;
    #1;
    check({tag, "_inready"}, 64'(InReady), 64'(model_ready(sel, ordy)));
    acc = iv && model_ready(sel, ordy) && !fl;
    if (fl) begin
      for (int c = 0; c < 8; c++) m_vld[c] = 0;
      m_cnt = 0;
    end else begin
      for (int c = 0; c < 8; c++) begin
        if (acc && int'(sel) == c) begin m_data[c] = din; m_vld[c] = 1; end
        else if (m_vld[c] && ordy[7 - c]) m_vld[c] = 0;
      end
      if (acc) m_cnt = (m_cnt + 1) % (1 << CW);
    end
    @(posedge Clk); #1;
    check_model(tag);
  endtask

  task automatic do_reset();
    Rst_n = 1'b0; Flush = 0; InValid = 0; Sel = '0; DataIn = '0; OutReady = '0;
    model_clear();
    repeat (2) @(posedge Clk);
    #1;
    check("rst_valid", 64'(OutValid), 64'h0);
    check("rst_count", 64'(AcceptCount), 64'h0);
    check("rst_data", DataOutFlat, 64'h0);
    check("rst_inready", 64'(InReady), 64'h1);
    @(negedge Clk) Rst_n = 1'b1;
    @(posedge Clk); #1;
  endtask

  vec_t tbl [19];

  initial begin
    // Hand-derived expectations; counter is 4 bits wide.
    tbl[0]  = mk(0,1,0,8'hA5,8'hFF, 1,8'h80,1, 1,0,8'hA5);
    tbl[1]  = mk(0,0,0,8'h00,8'hFF, 1,8'h00,1, 0,0,8'h00);
    tbl[2]  = mk(0,1,7,8'h11,8'hFE, 1,8'h01,2, 1,7,8'h11);
    tbl[3]  = mk(0,1,7,8'h22,8'hFE, 0,8'h01,2, 1,7,8'h11);
    tbl[4]  = mk(0,1,7,8'h22,8'hFF, 1,8'h01,3, 1,7,8'h22);
    tbl[5]  = mk(0,0,7,8'h00,8'hFE, 0,8'h01,3, 1,7,8'h22);
    for (int s = 0; s < 7; s++)
      tbl[6+s] = mk(0,1,3'(s),8'(8'h30+s),8'h00, 1,8'(8'hFF << (7-s)) | 8'h01, 4+s, 1,3'(s),8'(8'h30+s));
    tbl[13] = mk(0,0,7,8'h00,8'h00, 0,8'hFF,10, 1,7,8'h22);
    tbl[14] = mk(0,1,3,8'h55,8'hFF, 1,8'h10,11, 1,3,8'h55);
    tbl[15] = mk(0,1,0,8'h66,8'h00, 1,8'h90,12, 1,0,8'h66);
    tbl[16] = mk(0,1,7,8'h77,8'h00, 1,8'h91,13, 1,7,8'h77);
    tbl[17] = mk(1,1,1,8'h88,8'h00, 1,8'h00,0, 0,0,8'h00);
    tbl[18] = mk(0,0,1,8'h00,8'h00, 1,8'h00,0, 0,0,8'h00);

    do_reset();

    for (int i = 0; i < 19; i++) begin
      Flush = tbl[i].fl; InValid = tbl[i].iv; Sel = tbl[i].sel;
      DataIn = tbl[i].din; OutReady = tbl[i].ordy;
      #1;
      check($sformatf("tbl%0d_inready", i), 64'(InReady), 64'(tbl[i].exp_rdy));
      @(posedge Clk); #1;
      check($sformatf("tbl%0d_valid", i), 64'(OutValid), 64'(tbl[i].exp_vld));
      check($sformatf("tbl%0d_count", i), 64'(AcceptCount), 64'(tbl[i].exp_cnt));
      if (tbl[i].chk)
        check($sformatf("tbl%0d_data", i),
              64'(DataOutFlat[(7 - int'(tbl[i].chk_sel)) * 8 +: 8]), 64'(tbl[i].chk_data));
    end

    // Counter wrap: 17 back-to-back accepts into a 4-bit counter.
    do_reset();
    for (int i = 0; i < 17; i++) step(0, 1, 3'(i % 8), 8'(i), 8'hFF, "wrap");
    check("wrap_final", 64'(AcceptCount), 64'h1);

    // Asynchronous reset with beats pending, observed before any clock edge.
    for (int i = 0; i < 3; i++) step(0, 1, 3'(i), 8'(8'hC0 + i), 8'h00, "pre_rst");
    #2 Rst_n = 1'b0;
    #1;
    check("async_rst_valid", 64'(OutValid), 64'h0);
    check("async_rst_count", 64'(AcceptCount), 64'h0);
    check("async_rst_inready", 64'(InReady), 64'h1);

    // Random traffic against the model, upstream honours the hold rule.
    do_reset();
    begin
      bit pend = 0;
      logic [2:0] ps = '0;
      logic [7:0] pd = '0;
      for (int i = 0; i < 400; i++) begin
        bit fl = ($urandom_range(0, 19) == 0);
        bit iv;
        logic [7:0] ordy = 8'($urandom);
        if (!pend) begin
          iv = ($urandom_range(0, 3) != 0);
          ps = 3'($urandom);
          pd = 8'($urandom);
        end else iv = 1;
        pend = iv && !model_ready(ps, ordy);
        step(fl, iv, ps, pd, ordy, "rnd");
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
